// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle HI/LO multiply/accumulate and restoring divide unit
// One start/ready handshake fronts a latency-MUL_LAT multiplier and a WIDTH-cycle radix-2 divider.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 dbz_o
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              accept, is_div, b_zero, op_signed;
  logic              mul_done, fix_done;
  logic [WIDTH-1:0]  a_mag, b_mag;

  logic [W2-1:0]     mul_a, mul_b, mul_acc, mul_prod, mul_res;
  logic              mul_sub;

  logic [WIDTH-1:0]  div_b, div_rem, div_quo, rem_step, quo_step;
  logic [WIDTH:0]    div_shift, div_diff;
  logic              neg_q, neg_r, dbz_q;

  assign is_div    = op_i[2] & op_i[1];
  assign op_signed = ~op_i[0];
  assign b_zero    = (opb_i == '0);
  // An annul in the ready cycle drops a start issued alongside it.
  assign accept    = start_i && (state == S_IDLE) && !(annul_i && ready_o);
  assign busy_o    = (state != S_IDLE);

  assign a_mag = (op_signed && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign b_mag = (op_signed && opb_i[WIDTH-1]) ? -opb_i : opb_i;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_div)     state_nxt = S_MUL;
          else if (b_zero) state_nxt = S_FIX;
          else             state_nxt = S_DIV;
        end
      end
      S_MUL: begin
        if (annul_i || cnt == '0) state_nxt = S_IDLE;
      end
      S_DIV: begin
        if (annul_i)        state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mul_done = 1'b0;
    fix_done = 1'b0;
    case (state)
      S_MUL:   mul_done = !annul_i && (cnt == '0);
      S_FIX:   fix_done = !annul_i;
      default: ;
    endcase
  end

  // Operands are pre-extended to 2*WIDTH so one modular multiply serves signed and unsigned.
  assign mul_prod = mul_a * mul_b;
  assign mul_res  = mul_sub ? (mul_acc - mul_prod) : (mul_acc + mul_prod);

  assign div_shift = {div_rem, div_quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, div_b};
  assign rem_step  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_step  = {div_quo[WIDTH-2:0], ~div_diff[WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_sub <= 1'b0;
      div_b   <= '0;
      div_rem <= '0;
      div_quo <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= is_div ? CW'(WIDTH - 1) : CW'(MUL_LAT - 1);
      mul_a   <= op_signed ? {{WIDTH{opa_i[WIDTH-1]}}, opa_i} : {{WIDTH{1'b0}}, opa_i};
      mul_b   <= op_signed ? {{WIDTH{opb_i[WIDTH-1]}}, opb_i} : {{WIDTH{1'b0}}, opb_i};
      mul_acc <= (op_i[2] | op_i[1]) ? acc_i : '0;
      mul_sub <= op_i[2];
      div_b   <= b_mag;
      div_rem <= '0;
      div_quo <= a_mag;
      neg_q   <= op_signed & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
      neg_r   <= op_signed & opa_i[WIDTH-1];
      dbz_q   <= is_div & b_zero;
    end else if (state == S_MUL) begin
      cnt <= cnt - 1'b1;
    end else if (state == S_DIV) begin
      cnt <= cnt - 1'b1;
      // The final iteration stores sign-corrected results so FIX only has to publish them.
      if (cnt == '0) begin
        div_quo <= neg_q ? -quo_step : quo_step;
        div_rem <= neg_r ? -rem_step : rem_step;
      end else begin
        div_quo <= quo_step;
        div_rem <= rem_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_o  <= 1'b0;
      result_o <= '0;
      dbz_o    <= 1'b0;
    end else begin
      ready_o <= mul_done | fix_done;
      if (mul_done) begin
        result_o <= mul_res;
        dbz_o    <= 1'b0;
      end else if (fix_done) begin
        result_o <= dbz_q ? '0 : {div_rem, div_quo};
        dbz_o    <= dbz_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (WIDTH=32, MUL_LAT=2)
module tb_muldiv_unit;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst, start_i, annul_i;
  logic [2:0]       op_i;
  logic [W-1:0]     opa_i, opb_i;
  logic [2*W-1:0]   acc_i;
  logic             busy_o, ready_o, dbz_o;
  logic [2*W-1:0]   result_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] last_res = 64'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [63:0] res;
    logic        dbz;
    int          lat;
    string       name;
  } vec_t;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i),
    .opb_i(opb_i), .acc_i(acc_i), .annul_i(annul_i), .busy_o(busy_o),
    .ready_o(ready_o), .result_o(result_o), .dbz_o(dbz_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, prod, base, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op < 3'd6) begin
      prod = op[0] ? ua * ub : 64'(sa * sb);
      base = (op >= 3'd2) ? acc : 64'd0;
      res  = (op >= 3'd4) ? base - prod : base + prod;
      return {1'b0, res};
    end
    if (b == 32'd0) return {1'b1, 64'd0};
    if (op[0]) begin
      res = {32'(ua % ub), 32'(ua / ub)};
    end else begin
      sq  = sa / sb;
      sr  = sa % sb;
      res = {sr[31:0], sq[31:0]};
    end
    return {1'b0, res};
  endfunction

  task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] acc);
    start_i = 1'b1;
    op_i = op; opa_i = a; opb_i = b; acc_i = acc;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] acc);
    @(negedge clk);
    issue_now(op, a, b, acc);
  endtask

  // lat counts negedges after the accept edge; the first one lies in cycle k (lat 0).
  task automatic wait_ready(output int lat, output logic busy0);
    lat = -1;
    busy0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) busy0 = busy_o;
      if (ready_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_vec(input vec_t v);
    int lat;
    logic busy0;
    wait_ready(lat, busy0);
    chk({v.name, " lat"}, 64'(lat), 64'(v.lat));
    if (v.lat > 1) chk({v.name, " busy"}, 64'(busy0), 64'd1);
    if (lat >= 0) begin
      chk({v.name, " res"}, result_o, v.res);
      chk({v.name, " dbz"}, 64'(dbz_o), 64'(v.dbz));
      chk({v.name, " busy_rdy"}, 64'(busy_o), 64'd0);
    end
    last_res = v.res;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.op, v.a, v.b, v.acc);
    finish_vec(v);
  endtask

  task automatic count_ready(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o) n++;
    end
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    int n;
    logic [64:0] m;

    tbl[0] = '{3'd0, 32'hFFFFFFFE, 32'd3, 64'd0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 2, "mult"};
    tbl[1] = '{3'd1, 32'hFFFFFFFE, 32'd3, 64'd0, 64'h00000002_FFFFFFFA, 1'b0, 2, "multu"};
    tbl[2] = '{3'd4, 32'd2, 32'd3, 64'd5, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 2, "msub"};
    tbl[3] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 64'hFFFFFFFE_00000002, 1'b0, 2, "maddu"};
    tbl[4] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h10, 64'h00000000_00000011, 1'b0, 2, "madd"};
    tbl[5] = '{3'd6, 32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33, "div_neg"};
    tbl[6] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 1'b0, 33, "div_ovf"};
    tbl[7] = '{3'd7, 32'd5, 32'd0, 64'd0, 64'd0, 1'b1, 1, "divu_dbz"};
    tbl[8] = '{3'd7, 32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, 1'b0, 33, "divu"};
    tbl[9] = '{3'd6, 32'd7, 32'hFFFFFFFE, 64'd0, 64'h00000001_FFFFFFFD, 1'b0, 33, "div_negb"};

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    op_i = 3'd0; opa_i = '0; opb_i = '0; acc_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset dbz", 64'(dbz_o), 64'd0);
    rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Annul during MUL: no ready, result keeps the last value.
    issue(3'd0, 32'd5, 32'd5, 64'd0);
    annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0;
    count_ready(6, n);
    chk("annul_mul ready", 64'(n), 64'd0);
    chk("annul_mul result", result_o, last_res);
    chk("annul_mul busy", 64'(busy_o), 64'd0);

    // Back-to-back start in the ready cycle, then annul+start in the next ready cycle.
    run_vec(tbl[1]);
    issue_now(3'd7, 32'd100, 32'd7, 64'd0);
    finish_vec(tbl[8]);
    start_i = 1'b1; annul_i = 1'b1;
    op_i = 3'd0; opa_i = 32'd3; opb_i = 32'd3; acc_i = '0;
    @(posedge clk);
    #1 begin start_i = 1'b0; annul_i = 1'b0; end
    @(negedge clk);
    chk("annul_start busy", 64'(busy_o), 64'd0);
    count_ready(6, n);
    chk("annul_start ready", 64'(n), 64'd0);
    chk("annul_start result", result_o, tbl[8].res);

    // Reset part-way through a divide.
    issue(3'd6, 32'd1000, 32'hFFFFFFFD, 64'd0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_div busy", 64'(busy_o), 64'd0);
    chk("rst_div ready", 64'(ready_o), 64'd0);
    chk("rst_div result", result_o, 64'd0);
    chk("rst_div dbz", 64'(dbz_o), 64'd0);
    rst = 1'b1;
    count_ready(40, n);
    chk("rst_div late_ready", 64'(n), 64'd0);

    for (int i = 0; i < 60; i++) begin
      v.op  = 3'($urandom_range(0, 7));
      v.a   = $urandom;
      v.b   = $urandom;
      if ($urandom_range(0, 7) == 0) v.b = 32'd0;
      else if ($urandom_range(0, 3) == 0) v.b = 32'($urandom_range(0, 9)) - 32'd4;
      v.acc = {$urandom, $urandom};
      m = ref_model(v.op, v.a, v.b, v.acc);
      v.dbz = m[64];
      v.res = m[63:0];
      v.lat = (v.op < 3'd6) ? 2 : ((v.b == 32'd0) ? 1 : 33);
      v.name = $sformatf("rnd%0d", i);
      run_vec(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle HI/LO arithmetic unit for the EX stage, parametrised in operand width and multiplier latency. Executes MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU behind one start/ready handshake. It returns a double-width {HI, LO} result. EX holds its stall request while `busy_o` is high and writes HI/LO on `ready_o`.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 8; result is 2·WIDTH.
- `MUL_LAT`, 2: multiply/accumulate latency in cycles, 1..4.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  request; operands, op and acc sampled when accepted.
- `op_i`  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU, 110 DIV, 111 DIVU.
- `opa_i`  in  WIDTH  multiplicand / dividend.
- `opb_i`  in  WIDTH  multiplier / divisor.
- `acc_i`  in  2·WIDTH  forwarded {HI, LO} for MADD/MSUB.
- `annul_i`  in  1  flush; kills the in-flight operation.
- `busy_o`  out  1  operation in flight.
- `ready_o`  out  1  one-cycle pulse; `result_o` valid.
- `result_o`  out  2·WIDTH  {HI, LO}; held until the next `ready_o`.
- `dbz_o`  out  1  divide-by-zero flag; qualified by `ready_o`.

## Operation
- **Reset** (`rst`=0 at edge): state IDLE; `busy_o`=0, `ready_o`=0, `result_o`=0, `dbz_o`=0; divider registers and multiplier pipe cleared. Reset overrides start and annul and aborts any operation.
- **States:** IDLE, MUL, DIV, FIX.
  - Accept: `start_i`=1 and (state IDLE, or `ready_o`=1 this cycle).
  - `start_i` in any other state is ignored; no queueing.
- **IDLE → MUL** on accept of ops 000-101; counter loaded with MUL_LAT-1.
  - Product signed for even op codes, unsigned for odd.
  - MADD/MADDU: result = `acc_i` + product. MSUB/MSUBU: result = `acc_i` − product. Both modulo 2^(2·WIDTH).
  - After MUL_LAT cycles: write result, pulse ready, return to IDLE.
- **IDLE → DIV** on accept of ops 110/111 with `opb_i`≠0.
  - Signed op: operands converted to magnitudes; quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Radix-2 restoring division, one quotient bit per cycle for WIDTH cycles.
  - DIV → FIX applies sign correction; FIX writes {remainder, quotient} to `result_o` and pulses ready.
- **Divide by zero** (`opb_i`=0): no iteration; next cycle `result_o`=0, `dbz_o`=1, ready pulses. `dbz_o`=0 for every other completion.
- **Overflow case:** signed most-negative ÷ −1 → quotient = most-negative (wraps), remainder 0, `dbz_o`=0.
- **Annul:** `annul_i`=1 in a non-IDLE state → IDLE next edge, no `ready_o`, `result_o` unchanged.
  - Annul outranks a same-cycle start.
  - Annul in IDLE has no effect.
- **`busy_o`** = (state ≠ IDLE).

## Timing
- Latency LAT = cycles from the accept edge to the edge ending the ready cycle. Accept at edge k → `ready_o` high during cycle k+LAT.
  - Multiply: LAT = MUL_LAT.
  - Divide: LAT = WIDTH+1 (WIDTH iterations plus FIX).
  - Divide by zero: LAT = 1.
- `busy_o` rises the cycle after accept and falls in the cycle `ready_o` pulses.
- Back-to-back throughput: a start accepted in the ready cycle begins the next operation with no idle cycle.
- `result_o` and `dbz_o` are registered outputs and change only in ready cycles.
- No combinational path from any input to any output.

## Test plan
- **Reset mid-divide:** `rst`=0 at iteration 10 of a DIV → next cycle all outputs 0, IDLE; no ready pulse appears later.
- **Signed/unsigned multiply** (WIDTH=32, MUL_LAT=2): MULT a=0xFFFFFFFE, b=3 → `result_o`=0xFFFFFFFF_FFFFFFFA two cycles after accept. MULTU with the same operands → 0x00000002_FFFFFFFA.
- **Accumulate:** MSUB a=2, b=3, acc=0x0_00000005 → 0xFFFFFFFF_FFFFFFFF. MADDU a=b=0xFFFFFFFF, acc=1 → 0xFFFFFFFE_00000002.
- **Signed divide:** DIV a=−7, b=2 → {HI=−1, LO=−3}, ready exactly 33 cycles after accept. DIV 0x80000000 ÷ −1 → {0, 0x80000000}, `dbz_o`=0.
- **Divide by zero:** DIVU a=5, b=0 → ready after 1 cycle, `result_o`=0, `dbz_o`=1.
- **Annul vs. restart:**
  - Annul during MUL → no ready, `result_o` keeps its previous value.
  - Annul asserted together with a start in the ready cycle → IDLE, the start is dropped.
  - Without annul, a start in the ready cycle is accepted and its `ready_o` follows after its own LAT.
